// File: rtl/moore_det_pkg.sv
// Shared constants and helpers for the parametrised Moore pattern detector.
package moore_det_pkg;

  // Widest pattern the detector is meant to be built with.
  parameter int unsigned MAX_PAT_LEN = 16;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear and registered saturation flag.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q;

  // Next count: clear wins over increment; increment stops at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register plus saturation flag computed from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= &cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/moore_pattern_detect.sv
// Parametrised Moore serial pattern detector with run-time pattern reload,
// optional overlap and a saturating match counter.
module moore_pattern_detect
  import moore_det_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int unsigned     ST_W   = clog2(PAT_LEN + 1);
  localparam logic [ST_W-1:0] ST_DET = ST_W'(PAT_LEN);

  logic [ST_W-1:0]    state_q, state_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  // Last PAT_LEN-1 sampled bits, newest in bit 0.
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic               inc;

  // Next state: longest pattern prefix that is a suffix of the matched bits plus x.
  always_comb begin
    logic [PAT_LEN-1:0] cand;
    int                 base;
    int                 lim;
    int                 nxt;
    logic               hit;

    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    inc     = 1'b0;

    cand = {hist_q, x};
    // Non-overlapping mode restarts from scratch after a detection.
    base = (state_q == ST_DET && !OVERLAP) ? 0 : int'(state_q);
    lim  = (base + 1 > int'(PAT_LEN)) ? int'(PAT_LEN) : base + 1;
    nxt  = 0;
    for (int j = 1; j <= int'(PAT_LEN); j++) begin
      hit = (j <= lim);
      // cand[j-1] is the oldest of the last j bits and lines up with the pattern MSB.
      for (int i = 0; i < j; i++) begin
        if (cand[i] != pat_q[int'(PAT_LEN) - j + i]) hit = 1'b0;
      end
      if (hit) nxt = j;
    end

    if (pat_load) begin
      pat_d   = pat_in;
      state_d = '0;
    end else if (en) begin
      state_d = ST_W'(nxt);
      hist_d  = cand[PAT_LEN-2:0];
      inc     = (nxt == int'(PAT_LEN));
    end
  end

  // State, pattern and bit-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      pat_q   <= PATTERN;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
    end
  end

  // Moore output straight from the state register.
  assign z = (state_q == ST_DET);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .clr(cnt_clr),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );

endmodule

// File: tb/tb_moore_pattern_detect.sv
// Self-checking bench: four detector configurations share one stimulus stream and are
// compared every cycle against a suffix/prefix reference model.
module tb_moore_pattern_detect;

  localparam int M = 4;
  localparam int          P_LEN [M] = '{3, 3, 3, 5};
  localparam logic [15:0] P_PAT [M] = '{16'h5, 16'h5, 16'h5, 16'h16};
  localparam bit          P_OVL [M] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int          P_CW  [M] = '{8, 8, 2, 4};

  logic        clk, rst, x, en, pat_load, cnt_clr;
  logic [15:0] pat_bus;
  logic        z0, z1, z2, z3, s0, s1, s2, s3;
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;
  logic [3:0]  cnt3;
  logic [M-1:0] z_a, s_a;
  logic [15:0]  cnt_a [M];

  assign z_a = {z3, z2, z1, z0};
  assign s_a = {s3, s2, s1, s0};
  assign cnt_a[0] = {8'd0, cnt0};
  assign cnt_a[1] = {8'd0, cnt1};
  assign cnt_a[2] = {14'd0, cnt2};
  assign cnt_a[3] = {12'd0, cnt3};

  moore_pattern_detect u_dut0 (
    .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_bus[2:0]),
    .cnt_clr(cnt_clr), .z(z0), .match_cnt(cnt0), .cnt_sat(s0));

  moore_pattern_detect #(.OVERLAP(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_bus[2:0]),
    .cnt_clr(cnt_clr), .z(z1), .match_cnt(cnt1), .cnt_sat(s1));

  moore_pattern_detect #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_bus[2:0]),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(cnt2), .cnt_sat(s2));

  moore_pattern_detect #(.PAT_LEN(5), .PATTERN(5'b10110), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_bus[4:0]),
    .cnt_clr(cnt_clr), .z(z3), .match_cnt(cnt3), .cnt_sat(s3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Reference model: bits since the last reset/load/non-overlap detection, oldest first.
  bit          hq   [M][$];
  int          mk   [M];
  int          mcnt [M];
  logic [15:0] mpat [M];

  function automatic int longest(input int m);
    int n, best;
    bit ok;
    n = hq[m].size();
    best = 0;
    for (int j = 1; j <= P_LEN[m] && j <= n; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (hq[m][n - j + i] != mpat[m][P_LEN[m] - 1 - i]) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < M; m++) begin
      hq[m].delete();
      mk[m] = 0;
      mcnt[m] = 0;
      mpat[m] = P_PAT[m];
    end
  endtask

  task automatic model_step();
    bit det;
    for (int m = 0; m < M; m++) begin
      det = 1'b0;
      if (pat_load) begin
        mpat[m] = pat_bus & 16'((32'd1 << P_LEN[m]) - 1);
        hq[m].delete();
        mk[m] = 0;
      end else if (en) begin
        hq[m].push_back(x);
        if (hq[m].size() > P_LEN[m]) void'(hq[m].pop_front());
        mk[m] = longest(m);
        if (mk[m] == P_LEN[m]) begin
          det = 1'b1;
          if (!P_OVL[m]) hq[m].delete();
        end
      end
      if (cnt_clr) mcnt[m] = 0;
      else if (det && mcnt[m] < (1 << P_CW[m]) - 1) mcnt[m]++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of every DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int m = 0; m < M; m++) begin
          chk($sformatf("dut%0d z", m), int'(z_a[m]), int'(mk[m] == P_LEN[m]));
          chk($sformatf("dut%0d match_cnt", m), int'(cnt_a[m]), mcnt[m]);
          chk($sformatf("dut%0d cnt_sat", m), int'(s_a[m]),
              int'(mcnt[m] == (1 << P_CW[m]) - 1));
        end
      end
    end
  end

  task automatic step(input logic sx, input logic sen, input logic sload,
                      input logic [15:0] spat, input logic sclr);
    @(negedge clk);
    #2;
    x = sx; en = sen; pat_load = sload; pat_bus = spat; cnt_clr = sclr;
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle reset pulse that never spans a clock edge.
  task automatic pulse_rst();
    @(negedge clk);
    #2;
    en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst drops z", int'(z0), 0);
    chk("async rst clears cnt", int'(cnt0), 0);
    #1;
    rst = 1'b0;
  endtask

  bit s2x [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int s2z0 [5] = '{0, 0, 1, 0, 1};
  int s2z1 [5] = '{0, 0, 1, 0, 0};
  bit s3x [6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int s3z [6]  = '{0, 0, 1, 0, 0, 0};

  initial begin
    rst = 1'b1; x = 1'b0; en = 1'b0; pat_load = 1'b0; pat_bus = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset z", int'(z0), 0);
    chk("reset match_cnt", int'(cnt0), 0);
    chk("reset cnt_sat", int'(s0), 0);

    // Overlapping vs non-overlapping on 1,0,1,0,1.
    for (int i = 0; i < 5; i++) begin
      step(s2x[i], 1'b1, 1'b0, 16'h0, 1'b0);
      chk($sformatf("ovl z bit%0d", i), int'(z0), s2z0[i]);
      chk($sformatf("novl z bit%0d", i), int'(z1), s2z1[i]);
    end
    chk("ovl match_cnt", int'(cnt0), 2);
    chk("novl match_cnt", int'(cnt1), 1);

    // Reload pattern 110; then 1,1,0 detects once, 1,0,1 does not.
    step(1'b1, 1'b1, 1'b1, 16'h0006, 1'b0);
    chk("pat_load clears z", int'(z0), 0);
    chk("pat_load keeps cnt", int'(cnt0), 2);
    for (int i = 0; i < 6; i++) begin
      step(s3x[i], 1'b1, 1'b0, 16'h0, 1'b0);
      chk($sformatf("pat110 z bit%0d", i), int'(z0), s3z[i]);
    end

    // Enable gating: 1,0,<idle x4>,1 then z holds while idle.
    pulse_rst();
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("en=0 no detect", int'(z0), 0);
    end
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("en gated detect", int'(z0), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("z holds idle", int'(z0), 1);
    end

    // Saturation with CNT_W=2: five matches, then clear beats a match.
    pulse_rst();
    for (int i = 0; i < 11; i++) step(1'((i + 1) % 2), 1'b1, 1'b0, 16'h0, 1'b0);
    chk("sat match_cnt", int'(cnt2), 3);
    chk("sat cnt_sat", int'(s2), 1);
    chk("wide match_cnt", int'(cnt0), 5);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    chk("clr beats inc cnt", int'(cnt2), 0);
    chk("clr beats inc sat", int'(s2), 0);
    chk("clr edge still detects", int'(z0), 1);

    // Reset between bits 2 and 3 loses the partial match.
    pulse_rst();
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    pulse_rst();
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("no detect after rst", int'(z0), 0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("detect before rst", int'(z0), 1);
    pulse_rst();

    // Randomised traffic, including reloads, clears and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_rst();
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 32) == 0), 16'($urandom), 1'($urandom_range(0, 49) == 0));
      end
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
